// File: rtl/fetch_stage.sv
// RV64 instruction fetch: PC, memory request issue, prefetch FIFO,
// and the IFID output register with redirect flush and halt-on-zero.
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        IDIF_stall,
    output logic [31:0] IFID_instreg,
    output logic [63:0] IFID_npc,
    output logic        IFID_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, HALT} state_e;

    state_e        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] infl_q, infl_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW-1:0] srd_q, srd_d, swr_q, swr_d;
    logic          rdy_q, rdy_d;
    logic [31:0]   inst_q, inst_d;
    logic [63:0]   npc_q, npc_d;

    logic [31:0]   fdata_q [FIFO_DEPTH];
    logic [63:0]   fnpc_q  [FIFO_DEPTH];
    logic [63:0]   spc_q   [FIFO_DEPTH];

    logic [CW:0]   occ;
    logic          hs, push, load;
    logic          unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign occ = {1'b0, infl_q} + {1'b0, cnt_q};

    always_comb begin
        imem_req_valid = !reset && state_q == RUN && !redirect_valid
                         && occ < (CW+1)'(FIFO_DEPTH);
        hs   = imem_req_valid && imem_req_ready;
        push = imem_resp_valid && !redirect_valid && disc_q == '0;
        load = cnt_q != '0 && state_q == RUN && !redirect_valid
               && (!rdy_q || !IDIF_stall);

        pc_d    = hs ? pc_q + 64'd4 : pc_q;
        infl_d  = infl_q + CW'(hs) - CW'(imem_resp_valid);
        disc_d  = disc_q;
        if (imem_resp_valid && disc_q != '0)
            disc_d = disc_q - 1'b1;
        cnt_d   = cnt_q + CW'(push) - CW'(load);
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = load ? rd_q + 1'b1 : rd_q;
        swr_d   = hs ? swr_q + 1'b1 : swr_q;
        srd_d   = imem_resp_valid ? srd_q + 1'b1 : srd_q;
        rdy_d   = rdy_q;
        inst_d  = inst_q;
        npc_d   = npc_q;
        state_d = state_q;

        if (load) begin
            rdy_d  = 1'b1;
            inst_d = fdata_q[rd_q];
            npc_d  = fnpc_q[rd_q];
            if (fdata_q[rd_q] == 32'h0)
                state_d = HALT;
        end else if (rdy_q && !IDIF_stall) begin
            rdy_d = 1'b0;
        end

        // Side PC FIFO keeps running so discarded responses still pop it.
        if (redirect_valid) begin
            pc_d    = {redirect_pc[63:2], 2'b00};
            cnt_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
            rdy_d   = 1'b0;
            state_d = RUN;
            disc_d  = infl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            infl_q  <= '0;
            disc_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            srd_q   <= '0;
            swr_q   <= '0;
            rdy_q   <= 1'b0;
            inst_q  <= '0;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            infl_q  <= infl_d;
            disc_q  <= disc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            srd_q   <= srd_d;
            swr_q   <= swr_d;
            rdy_q   <= rdy_d;
            inst_q  <= inst_d;
            npc_q   <= npc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fdata_q[wr_q] <= imem_resp_data;
            fnpc_q[wr_q]  <= spc_q[srd_q] + 64'd4;
        end
        if (hs)
            spc_q[swr_q] <= pc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !load && cnt_q == CW'(FIFO_DEPTH)));
            assert (!(load && cnt_q == '0));
            assert (!(imem_resp_valid && infl_q == '0));
        end
    end

    assign imem_req_addr = pc_q;
    assign IFID_ready    = rdy_q;
    assign IFID_instreg  = inst_q;
    assign IFID_npc      = npc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: in-order memory model plus a
// queue-based reference of fetch/deliver behaviour, checked every cycle.
module tb_fetch_stage;
    localparam logic [63:0] RPC = 64'h1000;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        IDIF_stall;
    logic [31:0] IFID_instreg;
    logic [63:0] IFID_npc;
    logic        IFID_ready;

    fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .IDIF_stall(IDIF_stall),
        .IFID_instreg(IFID_instreg), .IFID_npc(IFID_npc),
        .IFID_ready(IFID_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat_min = 1, lat_max = 1, rdy_pct = 100, stall_pct = 0;
    bit force_stall = 0;
    logic [63:0] halt_addr = 64'h1;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int last_due = 0;

    // reference model
    logic [63:0] m_pc;
    bit          m_run;
    logic [63:0] m_pend[$];
    int          m_disc;
    logic [95:0] m_fifo[$];
    bit          m_rdy;
    logic [31:0] m_inst;
    logic [63:0] m_npc;

    // observation logs
    logic [63:0] iss[$];
    logic [63:0] del_npc[$];
    logic [31:0] del_inst[$];
    int          del_cyc[$];
    int          first_hs, first_rdy;

    function automatic logic [31:0] word(logic [63:0] a);
        if (a == halt_addr) return 32'h0;
        return a[31:0] ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        iss.delete();
        del_npc.delete();
        del_inst.delete();
        del_cyc.delete();
        first_hs = -1;
        first_rdy = -1;
    endtask

    task automatic tick();
        logic        ev, hsm, ld, hlt;
        logic [63:0] p;
        logic [95:0] h;
        int          lat, due;
        mreq_t       r;
        @(negedge clk);
        ev = !reset && m_run && !redirect_valid
             && (m_pend.size() + m_fifo.size() < D);
        chk("req_valid", {63'd0, imem_req_valid}, {63'd0, ev});
        if (ev) chk("req_addr", imem_req_addr, m_pc);
        chk("ifid_ready", {63'd0, IFID_ready}, {63'd0, m_rdy});
        if (m_rdy) begin
            chk("ifid_npc", IFID_npc, m_npc);
            chk("ifid_instreg", {32'd0, IFID_instreg}, {32'd0, m_inst});
        end
        if (!reset) begin
            if (imem_req_valid && imem_req_ready) begin
                iss.push_back(imem_req_addr);
                if (first_hs < 0) first_hs = cyc + 1;
            end
            if (IFID_ready && !IDIF_stall) begin
                del_npc.push_back(IFID_npc);
                del_inst.push_back(IFID_instreg);
                del_cyc.push_back(cyc);
            end
            if (IFID_ready && first_rdy < 0) first_rdy = cyc;
        end
        // memory
        if (reset) begin
            mq.delete();
            last_due = 0;
        end else begin
            if (imem_resp_valid && mq.size() > 0) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (due < last_due) due = last_due;
                last_due = due;
                r.addr = imem_req_addr;
                r.due = due;
                mq.push_back(r);
            end
        end
        // model
        hsm = ev && imem_req_ready;
        if (reset) begin
            m_pc = RPC; m_run = 1; m_pend.delete(); m_disc = 0;
            m_fifo.delete(); m_rdy = 0; m_inst = '0; m_npc = '0;
        end else if (redirect_valid) begin
            if (imem_resp_valid && m_pend.size() > 0) void'(m_pend.pop_front());
            m_disc = m_pend.size();
            m_fifo.delete();
            m_rdy = 0;
            m_run = 1;
            m_pc = {redirect_pc[63:2], 2'b00};
        end else begin
            ld = m_fifo.size() > 0 && m_run && (!m_rdy || !IDIF_stall);
            hlt = 0;
            if (ld) begin
                h = m_fifo.pop_front();
                m_rdy = 1;
                m_inst = h[95:64];
                m_npc = h[63:0];
                hlt = (m_inst == 32'h0);
            end else if (m_rdy && !IDIF_stall) begin
                m_rdy = 0;
            end
            if (imem_resp_valid && m_pend.size() > 0) begin
                p = m_pend.pop_front();
                if (m_disc > 0) m_disc--;
                else m_fifo.push_back({word(p), p + 64'd4});
            end
            if (hsm) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 64'd4;
            end
            if (hlt) m_run = 0;
        end
        @(posedge clk);
        cyc++;
        #1;
        redirect_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data = word(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        IDIF_stall = force_stall || ($urandom_range(99) < stall_pct);
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic redir(logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        tick();
        clear_logs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] t;
        bit found;
        reset = 1; imem_req_ready = 1; imem_resp_valid = 0;
        imem_resp_data = '0; redirect_valid = 0; redirect_pc = '0;
        IDIF_stall = 0;
        clear_logs();
        run(2);
        #1;
        chk("rst_ifid_ready", {63'd0, IFID_ready}, 64'd0);
        chk("rst_instreg", {32'd0, IFID_instreg}, 64'd0);
        chk("rst_npc", IFID_npc, 64'd0);
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_req_addr", imem_req_addr, 64'h1000);

        // streaming, 1-cycle memory
        reset = 0;
        clear_logs();
        #1;
        chk("first_req_valid", {63'd0, imem_req_valid}, 64'd1);
        run(20);
        chk("iss0", iss[0], 64'h1000);
        chk("iss1", iss[1], 64'h1004);
        chk("iss2", iss[2], 64'h1008);
        chk("del0", del_npc[0], 64'h1004);
        chk("del1", del_npc[1], 64'h1008);
        chk("ready_latency", 64'(first_rdy - first_hs), 64'd2);
        chk("throughput", 64'(del_cyc[4] - del_cyc[1]), 64'd3);

        // five stalled cycles
        force_stall = 1; IDIF_stall = 1;
        run(4);
        #1;
        chk("stall_cap_req", {63'd0, imem_req_valid}, 64'd0);
        chk("stall_ready", {63'd0, IFID_ready}, 64'd1);
        run(1);
        force_stall = 0; IDIF_stall = 0;
        run(20);
        for (int i = 0; i < del_npc.size(); i++)
            chk("stream_order", del_npc[i], RPC + 64'(4 * (i + 1)));

        // reset with FIFO full and output valid
        force_stall = 1; IDIF_stall = 1;
        run(8);
        reset = 1;
        run(1);
        force_stall = 0; IDIF_stall = 0;
        halt_addr = 64'h100C;
        reset = 0;
        clear_logs();
        #1;
        chk("mid_rst_ready", {63'd0, IFID_ready}, 64'd0);
        chk("mid_rst_instreg", {32'd0, IFID_instreg}, 64'd0);
        chk("mid_rst_npc", IFID_npc, 64'd0);
        chk("mid_rst_addr", imem_req_addr, 64'h1000);
        chk("mid_rst_valid", {63'd0, imem_req_valid}, 64'd1);

        // halt on zero word at 0x100C
        run(15);
        chk("halt_count", 64'(del_npc.size()), 64'd4);
        chk("halt_npc", del_npc[3], 64'h1010);
        chk("halt_inst", {32'd0, del_inst[3]}, 64'd0);
        #1;
        chk("halt_no_req", {63'd0, imem_req_valid}, 64'd0);
        redir(64'h3000);
        run(10);
        chk("resume_iss", iss[0], 64'h3000);
        chk("resume_del", del_npc[0], 64'h3004);
        halt_addr = 64'h1;

        // 64-bit PC wrap
        redir(64'hFFFF_FFFF_FFFF_FFF8);
        run(10);
        chk("wrap_iss1", iss[1], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_iss2", iss[2], 64'h0);
        chk("wrap_del1", del_npc[1], 64'h0);

        // 3-cycle memory, redirect with 3 in flight
        lat_min = 3; lat_max = 3;
        run(12);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mq.size() == 3) found = 1;
            else tick();
        end
        chk("three_inflight_seen", {63'd0, found}, 64'd1);
        redir(64'h2003);
        run(15);
        chk("redir_iss", iss[0], 64'h2000);
        chk("redir_del", del_npc[0], 64'h2004);

        // redirect during stall with a response arriving
        lat_min = 1; lat_max = 3;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (imem_resp_valid && IFID_ready) found = 1;
            else tick();
        end
        chk("stall_redir_setup", {63'd0, found}, 64'd1);
        IDIF_stall = 1;
        redirect_valid = 1;
        redirect_pc = 64'h4000;
        #1;
        chk("redir_no_req", {63'd0, imem_req_valid}, 64'd0);
        tick();
        clear_logs();
        #1;
        chk("redir_ready_drop", {63'd0, IFID_ready}, 64'd0);
        run(12);
        chk("stall_redir_iss", iss[0], 64'h4000);
        chk("stall_redir_del", del_npc[0], 64'h4004);

        // random phase
        lat_min = 1; lat_max = 4; rdy_pct = 70; stall_pct = 30;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3) begin
                t = {$urandom, $urandom};
                halt_addr = ($urandom_range(3) == 0)
                    ? {t[63:2], 2'b00} + 64'd8 * 64'($urandom_range(5))
                    : 64'h1;
                redirect_valid = 1;
                redirect_pc = t;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV64 in-order pipeline, directly upstream of the decode stage. It holds the fetch PC, issues word requests to instruction memory over a valid/ready channel, and buffers in-order responses in a small prefetch FIFO. It presents one instruction at a time to decode on the IFID_* bus under a valid/stall handshake. It supports PC redirect from branch/jump resolution, with wrong-path flush, and halts on the all-zero instruction word.

## Interface
- RESET_PC, 64'h0, fetch PC loaded on reset (bits [1:0] must be 0)
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >=2; also the cap on in-flight plus buffered requests
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  request valid
- imem_req_addr  out  64  word address of the request (the fetch PC)
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_resp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle pulse: resteer the fetch PC
- redirect_pc  in  64  new fetch PC; bits [1:0] are ignored and forced to 0
- IDIF_stall  in  1  decode cannot accept this cycle
- IFID_instreg  out  32  instruction presented to decode
- IFID_npc  out  64  PC of the presented instruction + 4
- IFID_ready  out  1  IFID_instreg/IFID_npc are valid

## Operation
- State FSM: RUN, HALT. Reset -> RUN.
- Issue:
  - imem_req_valid = (state==RUN) && !redirect_valid && (inflight + fifo_count < FIFO_DEPTH).
  - A handshake (valid && ready) increments inflight and advances the fetch PC by 4. The 64-bit add wraps modulo 2^64.
- Each FIFO entry stores {data, pc+4}. A per-request PC is carried in a side FIFO of the same depth, indexed with the in-flight requests.
- Response:
  - If discard_cnt > 0, the response is dropped and discard_cnt is decremented.
  - Otherwise the response is written to the FIFO.
  - In both cases inflight is decremented.
- Output register:
  - Loads the FIFO head when the FIFO is non-empty and either (IFID_ready==0) or (IFID_ready && !IDIF_stall).
  - A transfer completes on any cycle with IFID_ready && !IDIF_stall.
  - While IDIF_stall is high, IFID_* hold their values exactly.
  - When a transfer completes and the FIFO is empty, IFID_ready drops to 0 on the next edge.
- Halt:
  - When a word equal to 32'h0 is loaded into the output register, state -> HALT. That word is still presented.
  - In HALT, no new requests are issued. Responses to already-issued requests are still accepted into the FIFO, but they are not loaded into the output register.
  - HALT exits only via redirect or reset.
- Redirect (highest priority, overrides stall):
  - Next state: fetch PC <= {redirect_pc[63:2],2'b00}, FIFO cleared, IFID_ready <= 0, state <= RUN.
  - discard_cnt <= inflight, counted after this cycle's handshake/response updates.
  - imem_req_valid is 0 in the redirect cycle.
  - A response arriving in the redirect cycle is dropped.
- Reset mid-operation: all state cleared. The instruction memory is reset by the same signal, so no stale responses return.

## Timing
- Reset values: IFID_ready=0, IFID_instreg=0, IFID_npc=0, imem_req_valid=0, imem_req_addr=RESET_PC, inflight=0, discard_cnt=0, fifo empty, state=RUN.
- First imem_req_valid=1 is in the first cycle after reset deasserts.
- A response at edge N is written to the FIFO; it loads the output register at edge N+1. IFID_ready is therefore high 1 cycle after the response cycle.
- Sustained throughput is 1 instruction/cycle with a 1-cycle memory and no stall.
- Boundaries:
  - FIFO full plus in-flight at the cap: imem_req_valid=0.
  - A simultaneous FIFO push and pop while full is legal only because the issue cap prevents overflow. An assertion flags any overflow or underflow.
  - A response with inflight==0 is an error; assert on it.

## Test plan
- Reset, RESET_PC=64'h1000, 1-cycle memory returning addr-based words, no stall -> requests 0x1000, 0x1004, 0x1008…; IFID_npc 0x1004, 0x1008… on consecutive cycles; IFID_ready first high 2 cycles after the first handshake.
- Hold IDIF_stall=1 for 5 cycles mid-stream -> IFID_* frozen; requests stop after FIFO_DEPTH outstanding+buffered; on release, in-order delivery with no loss and no duplicates.
- 3-cycle memory latency with 3 requests in flight, redirect_pc=64'h2003 -> the 3 old responses are dropped; next request addr 0x2000; first delivered IFID_npc=0x2004.
- Redirect in the same cycle as IDIF_stall=1 and a response arrival -> IFID_ready=0 next cycle; the response is dropped; no request is issued in the redirect cycle.
- Memory returns 32'h0 at addr 0x100C -> word presented with IFID_npc=0x1010; imem_req_valid stays 0 afterwards; a redirect to 0x3000 resumes fetching.
- Reset asserted with FIFO full and IFID_ready=1 -> next cycle all outputs at reset values; fetch restarts at RESET_PC.
